stopwatch_up: RTL
=================

Name: stopwatch_up

Overview:
Count-up MM:SS stopwatch for the DE-board front panel, the up-counting companion to the countdown timer.
- Driven by pushbuttons; shows BCD time on HEX3..HEX0.
- Supports run/pause, lap (split) freeze of the display, and a minute alarm set on the switches.
- Sits at board top level beside the countdown timer; shares the 7-segment decoder and key conditioning.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per counted second.
- DEBOUNCE_CYCLES, 500000, cycles a raw key level must stay stable to be accepted.

Ports:
- CLOCK_50  in  1  system clock.
- KEY  in  4  active-low pushbuttons. KEY[0] = asynchronous active-low reset. KEY[1] = start/stop. KEY[2] = lap. KEY[3] = clear.
- SW  in  8  alarm target minutes in BCD: SW[7:4] tens, SW[3:0] units.
- LEDR  out  10  status/alarm LEDs.
- HEX0  out  7  seconds units, active-low segments.
- HEX1  out  7  seconds tens, active-low segments.
- HEX2  out  7  minutes units, active-low segments.
- HEX3  out  7  minutes tens, active-low segments.

Behaviour:
- Reset (KEY[0]=0, async, all flops):
  - state=IDLE; count digits and lap digits = 0; prescaler = 0; alarm = 0; blink = 0.
  - Outputs: LEDR = 0; HEX shows 00:00.
- Key conditioning for KEY[3:1]:
  - 2-flop synchronizer, then debounce counter; debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - press = 1-cycle pulse on debounced 1->0 transition.
  - Release produces nothing. Holding a key produces exactly one press.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP; tick = 1 when prescaler == TICK_DIV-1, then wraps to 0.
  - Retains its value in PAUSE, so resume is sub-second accurate.
  - Zeroed by clear.
- blink: toggles when prescaler hits TICK_DIV-1 or TICK_DIV/2-1 (≈1 Hz). The prescaler also free-runs in OVERFLOW and while alarm=1, to drive blink.
- BCD increment on tick, same cycle, registered result:
  - su 9->0 carries into st; st 5->0 carries into mu; mu 9->0 carries into mt.
  - At 99:59, a tick does not wrap: digits hold 99:59 and state -> OVERFLOW.
- States and transitions:
  - IDLE: KEY[1] -> RUN.
  - RUN: KEY[1] -> PAUSE; KEY[2] -> LAP, latching the current digits into the lap registers.
  - LAP: counting continues, HEX shows lap registers. KEY[2] -> RUN (live display); KEY[1] -> PAUSE (live display).
  - PAUSE: KEY[1] -> RUN; KEY[3] -> IDLE with digits and prescaler cleared.
  - OVERFLOW: KEY[3] -> IDLE with clear; other keys ignored.
  - KEY[3] is ignored in RUN and LAP.
- Simultaneous presses in one cycle: priority KEY[1] > KEY[2] > KEY[3]; lower-priority presses are dropped.
- Tick and key press in the same cycle: the increment is applied, then the transition. A lap latch captures the pre-increment value.
- Alarm:
  - Target is valid when both SW nibbles are ≤9 and the target is nonzero.
  - When a tick produces digits == target:00, alarm <= 1.
  - Cleared only by clear or reset. A SW change does not clear it.
- LEDR:
  - LEDR[0] = 1 in RUN/LAP.
  - LEDR[1] = 1 in LAP.
  - LEDR[2] = 1 in PAUSE.
  - LEDR[8:3] = 0.
  - LEDR[9] = alarm & blink.
  - In OVERFLOW, LEDR[9:0] = {10{blink}}, overriding all of the above.
- HEX outputs: combinational decode of the displayed digit via dec2_7seg. Latency is 0 cycles from the digit registers.

Decomposition:
- Shared package: state encoding (IDLE, RUN, PAUSE, LAP, OVERFLOW), BCD digit limits (9, 5), and the active-low 7-segment constants shared with dec2_7seg.
- One sub-module: key_press_detect (synchronizer + debounce + falling-edge pulse), instantiated 3×. It is also reusable by the countdown timer.

Test Plan:
All scenarios use TICK_DIV=10 and DEBOUNCE_CYCLES=4.
- Reset, then KEY[1] press held 10 cycles -> exactly one RUN entry; after 30 cycles HEX shows 00:03; LEDR = 10'b0000000001.
- Preload to 00:59 in RUN, one tick -> 01:00. Preload 09:59 -> 10:00.
- In RUN at 00:05, press KEY[2] -> HEX frozen at 00:05 for 50 cycles while internal count reaches 00:10. Press KEY[2] again -> HEX shows 00:10.
- Pause at prescaler=6, wait 100 cycles, resume -> next tick exactly 4 cycles after resume. KEY[3] in PAUSE -> 00:00, IDLE.
- Preload 99:58, run 2 ticks -> HEX 99:59, state OVERFLOW, LEDR alternates 0x3FF/0x000 every 5 cycles. KEY[1] ignored; KEY[3] -> IDLE 00:00.
- SW=8'h01, run to 01:00 -> LEDR[9] blinks. A 2-cycle glitch on KEY[1] -> no state change. KEY[0] asserted mid-RUN -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/stopwatch_up_pkg.sv
// rtl/stopwatch_up_pkg.sv - shared state encoding, BCD limits and 7-segment decode
package stopwatch_up_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_LAP,
        ST_OVERFLOW
    } state_e;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } mmss_t;

    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;
    localparam mmss_t      MMSS_MAX    = 16'h9959;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] dec2_7seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Caller handles 99:59; mt is never incremented past 9 here
    function automatic mmss_t mmss_inc(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.su != DIGIT_MAX_9) begin
            r.su = t.su + 4'd1;
        end else begin
            r.su = 4'd0;
            if (t.st != DIGIT_MAX_5) begin
                r.st = t.st + 4'd1;
            end else begin
                r.st = 4'd0;
                if (t.mu != DIGIT_MAX_9) begin
                    r.mu = t.mu + 4'd1;
                end else begin
                    r.mu = 4'd0;
                    r.mt = t.mt + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_up_if.sv
// rtl/stopwatch_up_if.sv - front-panel switch, LED and 7-segment bundle
interface stopwatch_up_if;
    logic [7:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;

    modport master (output SW, input LEDR, HEX0, HEX1, HEX2, HEX3);
    modport slave  (input SW, output LEDR, HEX0, HEX1, HEX2, HEX3);
endinterface

// File: rtl/stopwatch_up_key_press_detect.sv
// rtl/stopwatch_up_key_press_detect.sv - synchronizer, debounce and press pulse for one active-low key
module key_press_detect #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level restarts the run of differing samples
    always_comb begin
        sync_d   = {sync_q[0], key_n};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press    = 1'b0;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
            press    = stable_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/stopwatch_up.sv
// rtl/stopwatch_up.sv - count-up MM:SS stopwatch with lap freeze and minute alarm
module stopwatch_up
    import stopwatch_up_pkg::*;
#(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic          CLOCK_50,
    input  logic [3:0]    KEY,
    stopwatch_up_if.slave panel
);
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);

    logic rst_n;
    assign rst_n = KEY[0];

    logic [3:1] press;
    for (genvar gi = 1; gi < 4; gi++) begin : g_key
        key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (CLOCK_50),
            .rst_n (rst_n),
            .key_n (KEY[gi]),
            .press (press[gi])
        );
    end

    state_e        state_q, state_d;
    mmss_t         count_q, count_d;
    mmss_t         lap_q, lap_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          alarm_q, alarm_d;
    logic          blink_q, blink_d;

    logic counting, presc_run, tick, wrap, target_valid;
    logic key1, key2, key3;

    assign counting     = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign presc_run    = counting || (state_q == ST_OVERFLOW) || alarm_q;
    assign tick         = counting && (presc_q == PRESC_LAST);
    assign wrap         = tick && (count_q == MMSS_MAX);
    assign target_valid = (panel.SW[7:4] <= DIGIT_MAX_9) && (panel.SW[3:0] <= DIGIT_MAX_9)
                          && (panel.SW != 8'h00);
    assign key1 = press[1];
    assign key2 = press[2] && !press[1];
    assign key3 = press[3] && !press[2] && !press[1];

    // Increment and lap latch both look at count_q, so a same-cycle lap captures the old time
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lap_d   = lap_q;
        presc_d = presc_q;
        alarm_d = alarm_q;
        blink_d = blink_q;

        if (presc_run) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            if ((presc_q == PRESC_LAST) || (presc_q == PRESC_HALF)) begin
                blink_d = ~blink_q;
            end
        end

        if (tick && !wrap) begin
            count_d = mmss_inc(count_q);
            if (target_valid && (count_d == {panel.SW, 8'h00})) begin
                alarm_d = 1'b1;
            end
        end

        if (wrap) begin
            state_d = ST_OVERFLOW;
        end else begin
            case (state_q)
                ST_IDLE: if (key1) state_d = ST_RUN;
                ST_RUN: begin
                    if (key1) begin
                        state_d = ST_PAUSE;
                    end else if (key2) begin
                        state_d = ST_LAP;
                        lap_d   = count_q;
                    end
                end
                ST_LAP: begin
                    if (key1)      state_d = ST_PAUSE;
                    else if (key2) state_d = ST_RUN;
                end
                ST_PAUSE, ST_OVERFLOW: begin
                    if (key1 && (state_q == ST_PAUSE)) begin
                        state_d = ST_RUN;
                    end else if (key3) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        presc_d = '0;
                        alarm_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            lap_q   <= '0;
            presc_q <= '0;
            alarm_q <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            presc_q <= presc_d;
            alarm_q <= alarm_d;
            blink_q <= blink_d;
        end
    end

    mmss_t shown;
    assign shown      = (state_q == ST_LAP) ? lap_q : count_q;
    assign panel.HEX0 = dec2_7seg(shown.su);
    assign panel.HEX1 = dec2_7seg(shown.st);
    assign panel.HEX2 = dec2_7seg(shown.mu);
    assign panel.HEX3 = dec2_7seg(shown.mt);

    logic [9:0] led;
    always_comb begin
        led = '0;
        if (state_q == ST_OVERFLOW) begin
            led = {10{blink_q}};
        end else begin
            led[0] = counting;
            led[1] = (state_q == ST_LAP);
            led[2] = (state_q == ST_PAUSE);
            led[9] = alarm_q & blink_q;
        end
    end
    assign panel.LEDR = led;
endmodule
